// File: rtl/cpu_defs.sv
`default_nettype none
// ============================================================================
// cpu_defs : shared widths, opcodes and fetch state encoding for the pcpu
// Rev 1.0
// ============================================================================
package cpu_defs;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 16;

  localparam logic [4:0]  OP_NOP     = 5'b00000;
  localparam logic [4:0]  OP_HALT    = 5'b00001;
  localparam logic [15:0] NOP_WORD_C = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
// fetch_skid_buf : 2-entry FIFO holding {instruction, pc} while decode stalls
// Rev 1.0
// ============================================================================
module fetch_skid_buf #(
  parameter int W = 24
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   count_q, count_d;

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) e0_d = push_data;
          else                 e1_d = push_data;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          e0_d    = e1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            e0_d = push_data;
          end else begin
            e0_d = e1_q;
            e1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e0_q    <= '0;
      e1_q    <= '0;
      count_q <= 2'd0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      count_q <= count_d;
    end
  end

  assign head_data = e0_q;
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/pcpu_fetch_stage.sv
`default_nettype none
// ============================================================================
// pcpu_fetch_stage : instruction fetch with skid buffer, branch redirect, HALT
// Rev 1.0
// ============================================================================
module pcpu_fetch_stage
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter logic [4:0]        HALT_OP  = OP_HALT,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP_WORD_C
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] i_addr,
  output logic              i_re,
  input  logic [DATA_W-1:0] i_datain,
  output logic [DATA_W-1:0] id_ir,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              halted
);

  localparam int BUF_W = DATA_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] id_ir_q, id_ir_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;
  logic              id_valid_q, id_valid_d;
  logic              halted_q, halted_d;

  logic              buf_push, buf_pop, buf_flush;
  logic [1:0]        buf_count;
  logic [BUF_W-1:0]  buf_head, ret_word, load_word;
  logic              running, redirect, credit_ok, load_en;

  assign ret_word  = {i_datain, inflight_pc_q};
  assign running   = (state_q == ST_RUN);
  assign redirect  = enable && running && branch_taken;
  // A read is allowed only if its word is guaranteed a buffer slot on return.
  assign credit_ok = ({1'b0, buf_count} + {2'b00, inflight_q}) < 3'd2;
  assign i_re      = !reset && enable && running && !branch_taken && credit_ok;
  assign i_addr    = fetch_pc_q;

  fetch_skid_buf #(.W(BUF_W)) u_skid (
    .clock    (clock),
    .reset    (reset),
    .push     (buf_push),
    .pop      (buf_pop),
    .flush    (buf_flush),
    .push_data(ret_word),
    .head_data(buf_head),
    .count    (buf_count)
  );

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = i_re;
    inflight_pc_d = inflight_pc_q;
    id_ir_d       = id_ir_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;
    halted_d      = halted_q;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_flush     = 1'b0;
    load_en       = 1'b0;
    load_word     = ret_word;

    if (i_re) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      inflight_pc_d = fetch_pc_q;
    end

    if (!enable) begin
      // Frozen, but memory data already on its way must not be lost.
      buf_push = inflight_q;
    end else if (redirect) begin
      buf_flush  = 1'b1;
      fetch_pc_d = branch_target;
      id_ir_d    = NOP_WORD;
      id_valid_d = 1'b0;
    end else begin
      if (start && !running) begin
        state_d    = ST_RUN;
        fetch_pc_d = '0;
        buf_flush  = 1'b1;
        halted_d   = 1'b0;
      end

      if (stall) begin
        buf_push = inflight_q;
      end else if (buf_count != 2'd0) begin
        load_en   = 1'b1;
        load_word = buf_head;
        buf_pop   = 1'b1;
        buf_push  = inflight_q;
      end else if (inflight_q) begin
        load_en = 1'b1;
      end

      if (!stall) begin
        if (load_en) begin
          id_ir_d    = load_word[BUF_W-1 -: DATA_W];
          id_pc_d    = load_word[ADDR_W-1:0];
          id_valid_d = 1'b1;
        end else begin
          id_ir_d    = NOP_WORD;
          id_valid_d = 1'b0;
        end
      end

      if (load_en && running && (load_word[BUF_W-1 -: 5] == HALT_OP)) begin
        state_d    = ST_HALTED;
        halted_d   = 1'b1;
        buf_flush  = 1'b1;
        inflight_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      id_ir_q       <= NOP_WORD;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      id_ir_q       <= id_ir_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign id_ir    = id_ir_q;
  assign id_pc    = id_pc_q;
  assign id_valid = id_valid_q;
  assign halted   = halted_q;

endmodule
`default_nettype wire

// File: doc/pcpu_fetch_stage.md
Name: pcpu_fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit pipelined CPU; sits directly upstream of decode and produces id_ir and its PC.
- Drives a synchronous instruction memory with 1-cycle read latency.
- Absorbs decode stalls with a 2-entry skid buffer and redirects on taken branches from EX.
- Stops fetching on HALT.
- Controlled by the same enable/start pair as the CPU top.

Parameters:
ADDR_W, 8, instruction address width (word addressed)
DATA_W, 16, instruction width
HALT_OP, 5'b00001, opcode field ir[15:11] that halts fetch
NOP_WORD, 16'h0000, bubble value driven on id_ir when not valid

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high
enable  input  1  global freeze when 0: no state changes, no memory reads issued
start  input  1  pulse; starts fetch from address 0 when IDLE or HALTED
stall  input  1  decode cannot accept; hold id_ir/id_pc/id_valid
branch_taken  input  1  redirect request from EX
branch_target  input  ADDR_W  redirect address
i_addr  output  ADDR_W  instruction memory read address
i_re  output  1  instruction memory read enable
i_datain  input  DATA_W  memory read data, valid the cycle after i_re
id_ir  output  DATA_W  instruction to decode
id_pc  output  ADDR_W  address of id_ir
id_valid  output  1  id_ir holds a real instruction
halted  output  1  HALT has been delivered to decode

Behaviour:
- Reset values: state=IDLE, fetch_pc=0, buffer empty, in-flight cleared, i_re=0, i_addr=0, id_ir=NOP_WORD, id_pc=0, id_valid=0, halted=0.
- Reset wins over every other input. A reset mid-operation discards buffered and in-flight words.
- enable=0: all registers hold and i_re=0. A returning read is still captured into the buffer, so memory data is never lost.
- States:
  - IDLE -> RUN on start&enable; fetch_pc<=0.
  - RUN -> HALTED when a word with ir[15:11]==HALT_OP loads into id_ir.
  - HALTED -> RUN on start&enable; fetch_pc<=0, buffer flushed, halted<=0.
  - start while in RUN is ignored.
- Issue rule (RUN only): i_re=1 with i_addr=fetch_pc when buffer_count + inflight < 2 and no branch this cycle. fetch_pc increments by 1 and wraps 8'hFF -> 8'h00.
- Returning word (inflight and not killed):
  - Loads id_ir directly when the output register is free or is being consumed this cycle.
  - Otherwise it is pushed into the buffer. The credit rule guarantees the buffer never overflows.
- Output update, when enable & !stall:
  - id_ir/id_pc take the oldest buffered word if any, else the returning word.
  - If neither exists: id_ir<=NOP_WORD, id_valid<=0.
  - Order is strictly FIFO.
- stall=1: id_ir/id_pc/id_valid hold. Fetch continues until 2 words are outstanding or buffered, then i_re=0.
- Latency: start sampled at edge E0 -> i_re=1 addr 0 after E0 -> id_valid=1 with word 0 after E2. Steady throughput is 1 instruction/cycle.
- branch_taken (enable=1, state RUN):
  - Takes priority over stall and over the issue rule.
  - At the edge: buffer flushed, in-flight word marked killed, id_ir<=NOP_WORD, id_valid<=0, fetch_pc<=branch_target.
  - The next cycle issues a read at branch_target.
  - Branch penalty: the target reaches id_ir 2 edges after the branch edge.
- HALT:
  - The HALT word itself is presented with id_valid=1 and halted<=1 on that edge.
  - Further reads stop; the buffer and in-flight word are discarded.
  - Once decode accepts it (!stall), the stage drives NOP with id_valid=0.
- A branch in the same cycle as a HALT load takes priority: the HALT is flushed and halted stays 0.

Decomposition:
- Shared package cpu_defs: ADDR_W, DATA_W, opcode constants (NOP, HALT), NOP_WORD, fetch state encoding (IDLE, RUN, HALTED).
- One sub-module, fetch_skid_buf: 2-entry FIFO with push, pop, flush, count, and data+pc width of DATA_W+ADDR_W.
- Top-level FSM, credit counter, and output register stay in pcpu_fetch_stage.

Test Plan:
- Reset, then start with mem[0..3]=16'h1001,16'h2002,16'h3003,16'h0800 (HALT) -> id_ir sequence 1001,2002,3003,0800 on consecutive cycles from 2 edges after start; id_pc 0,1,2,3; halted=1 with 0800; i_re=0 afterwards.
- stall held 3 cycles while id_ir=2002 -> id_ir holds 2002; at most 2 reads outstanding; after release 3003 follows with no loss or duplication.
- branch_taken with target 8'h40 while stall=1 and buffer full -> next id_ir=NOP with valid 0; i_addr=40 next cycle; id_ir=mem[40h] 2 edges after branch.
- enable=0 for 4 cycles mid-stream -> no i_re pulses and all outputs frozen; stream resumes in order.
- fetch_pc at 8'hFF -> next read address 8'h00.
- reset asserted mid-stream with an in-flight read -> outputs at reset values next edge; the returning word is discarded; a later start refetches from 0.
